// File: rtl/dt_scan_scheduler.sv
// Two-pass raster scheduler for the distance-transform engine: fetches each interior
// object pixel and its four pass-specific neighbours, then writes the unit's result back.
module dt_scan_scheduler #(
    parameter int IMG_W = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] dtu_a,
    output logic [DW-1:0] dtu_b,
    output logic [DW-1:0] dtu_c,
    output logic [DW-1:0] dtu_d,
    output logic [DW-1:0] dtu_ref,
    output logic          dtu_bwd,
    input  logic [DW-1:0] dtu_result
);

    localparam int            CW = AW / 2;
    localparam logic [CW-1:0] LO = CW'(1);
    localparam logic [CW-1:0] HI = CW'(IMG_W - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD_C,
        CHK,
        RD_NB,
        CAP,
        WR,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [1:0]    k;
    logic          last_bwd;
    logic [CW-1:0] adv_row;
    logic [CW-1:0] adv_col;
    logic          adv_bwd;
    logic          new_pass;
    logic [CW-1:0] nb_row;
    logic [CW-1:0] nb_col;

    assign last_bwd = dtu_bwd && (row == LO) && (col == LO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RD_C;
            RD_C:    state_nxt = CHK;
            CHK: begin
                if (mem_rdata != '0) begin
                    state_nxt = RD_NB;
                end else begin
                    state_nxt = last_bwd ? DONE : RD_C;
                end
            end
            RD_NB:   if (k == 2'd3) state_nxt = CAP;
            CAP:     state_nxt = WR;
            WR:      state_nxt = last_bwd ? DONE : RD_C;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next scan position; the forward pass hands over to the backward pass at the same
    // corner pixel, and the end of the backward pass rewinds to the reset position.
    always_comb begin
        adv_row  = row;
        adv_col  = col;
        adv_bwd  = dtu_bwd;
        new_pass = 1'b0;
        if (!dtu_bwd) begin
            if (col == HI) begin
                if (row == HI) begin
                    adv_bwd  = 1'b1;
                    new_pass = 1'b1;
                end else begin
                    adv_row = row + CW'(1);
                    adv_col = LO;
                end
            end else begin
                adv_col = col + CW'(1);
            end
        end else begin
            if (col == LO) begin
                if (row == LO) begin
                    adv_bwd = 1'b0;
                end else begin
                    adv_row = row - CW'(1);
                    adv_col = HI;
                end
            end else begin
                adv_col = col - CW'(1);
            end
        end
    end

    always_comb begin
        nb_row = row;
        nb_col = col;
        if (!dtu_bwd) begin
            unique case (k)
                2'd0: begin nb_row = row - CW'(1); nb_col = col - CW'(1); end
                2'd1: begin nb_row = row - CW'(1); end
                2'd2: begin nb_row = row - CW'(1); nb_col = col + CW'(1); end
                default: begin nb_col = col - CW'(1); end
            endcase
        end else begin
            unique case (k)
                2'd0: begin nb_col = col + CW'(1); end
                2'd1: begin nb_row = row + CW'(1); nb_col = col - CW'(1); end
                2'd2: begin nb_row = row + CW'(1); end
                default: begin nb_row = row + CW'(1); nb_col = col + CW'(1); end
            endcase
        end
    end

    // Read data lags its strobe by one cycle, so neighbour k lands while k+1 is being read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row     <= LO;
            col     <= LO;
            dtu_bwd <= 1'b0;
            k       <= 2'd0;
            dtu_a   <= '0;
            dtu_b   <= '0;
            dtu_c   <= '0;
            dtu_d   <= '0;
            dtu_ref <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row     <= LO;
                        col     <= LO;
                        dtu_bwd <= 1'b0;
                        k       <= 2'd0;
                        dtu_a   <= '0;
                        dtu_b   <= '0;
                        dtu_c   <= '0;
                        dtu_d   <= '0;
                        dtu_ref <= '0;
                    end
                end
                CHK: begin
                    if (mem_rdata != '0) begin
                        dtu_ref <= mem_rdata;
                        k       <= 2'd0;
                    end else begin
                        row     <= adv_row;
                        col     <= adv_col;
                        dtu_bwd <= adv_bwd;
                        if (new_pass) begin
                            dtu_a   <= '0;
                            dtu_b   <= '0;
                            dtu_c   <= '0;
                            dtu_d   <= '0;
                            dtu_ref <= '0;
                        end
                    end
                end
                RD_NB: begin
                    k <= k + 2'd1;
                    unique case (k)
                        2'd1:    dtu_a <= mem_rdata;
                        2'd2:    dtu_b <= mem_rdata;
                        2'd3:    dtu_c <= mem_rdata;
                        default: ;
                    endcase
                end
                CAP: begin
                    dtu_d <= mem_rdata;
                end
                WR: begin
                    row     <= adv_row;
                    col     <= adv_col;
                    dtu_bwd <= adv_bwd;
                    if (new_pass) begin
                        dtu_a   <= '0;
                        dtu_b   <= '0;
                        dtu_c   <= '0;
                        dtu_d   <= '0;
                        dtu_ref <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_rd    = (state == RD_C) || (state == RD_NB);
        mem_wr    = (state == WR);
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            RD_C:  mem_addr = {row, col};
            RD_NB: mem_addr = {nb_row, nb_col};
            WR: begin
                mem_addr  = {row, col};
                mem_wdata = dtu_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dt_scan_scheduler.sv
// Directed bench for dt_scan_scheduler on a 16x16 image: RAM and distance-unit models,
// an access log sampled on the falling edge, and checks against hand-computed values.
module tb_dt_scan_scheduler;

    localparam int W   = 16;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int N   = W - 2;
    localparam int PIX = N * N;
    localparam int ZERO_LAT = 1 + 2 * 2 * PIX + 1;
    localparam int ONE_LAT  = ZERO_LAT + 2 * 6;

    typedef struct {
        int          cyc;
        bit          rd;
        bit          wr;
        int          addr;
        int          wdata;
        bit          bwd;
        logic [39:0] ops;
    } acc_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] dtu_a;
    logic [DW-1:0] dtu_b;
    logic [DW-1:0] dtu_c;
    logic [DW-1:0] dtu_d;
    logic [DW-1:0] dtu_ref;
    logic          dtu_bwd;
    logic [DW-1:0] dtu_result;

    logic [DW-1:0] ram [W*W];
    logic          tb_clr;
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_data;

    acc_t log_q[$];
    int   cyc = 0;
    int   done_total = 0;
    int   both_total = 0;
    int   border_wr = 0;
    int   tests = 0;
    int   failures = 0;

    dt_scan_scheduler #(.IMG_W(W), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dtu_a      (dtu_a),
        .dtu_b      (dtu_b),
        .dtu_c      (dtu_c),
        .dtu_d      (dtu_d),
        .dtu_ref    (dtu_ref),
        .dtu_bwd    (dtu_bwd),
        .dtu_result (dtu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM with a bench-side port for loading images between runs.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
        if (tb_clr) begin
            for (int i = 0; i < W * W; i++) ram[i] <= '0;
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
        end else if (tb_we) begin
            ram[tb_addr] <= tb_data;
        end
    end

    // Distance unit: forward = min(nb)+1, backward = min(centre, min(nb)+1).
    always_comb begin
        logic [DW-1:0] m;
        logic [DW-1:0] p;
        m = dtu_a;
        if (dtu_b < m) m = dtu_b;
        if (dtu_c < m) m = dtu_c;
        if (dtu_d < m) m = dtu_d;
        p = (m == 8'hFF) ? m : m + 8'd1;
        dtu_result = (dtu_bwd && dtu_ref < p) ? dtu_ref : p;
    end

    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            log_q.push_back('{cyc, mem_rd, mem_wr, int'(mem_addr), int'(mem_wdata), dtu_bwd,
                              {dtu_a, dtu_b, dtu_c, dtu_d, dtu_ref}});
        end
        if (done) done_total <= done_total + 1;
        if (mem_rd && mem_wr) both_total <= both_total + 1;
        if (mem_wr && (int'(mem_addr) / W == 0 || int'(mem_addr) / W == W - 1 ||
                       int'(mem_addr) % W == 0 || int'(mem_addr) % W == W - 1))
            border_wr <= border_wr + 1;
    end

    function automatic int a_of(input int r, input int c);
        return r * W + c;
    endfunction

    function automatic int count_acc(input int from, input bit want_wr);
        int n = 0;
        for (int i = from; i < log_q.size(); i++)
            if (want_wr ? log_q[i].wr : log_q[i].rd) n++;
        return n;
    endfunction

    function automatic int find_wr(input int from, input int nth);
        int n = 0;
        for (int i = from; i < log_q.size(); i++) begin
            if (log_q[i].wr) begin
                if (n == nth) return i;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int signature(input int from);
        int s = 0;
        for (int i = from; i < log_q.size(); i++)
            s = s * 31 + log_q[i].addr + (int'(log_q[i].wr) << 9) + (int'(log_q[i].bwd) << 10)
                + (log_q[i].wdata << 12) + (log_q[i].cyc - log_q[from].cyc);
        return s;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_ram();
        @(negedge clk) tb_clr = 1'b1;
        @(negedge clk) tb_clr = 1'b0;
    endtask

    task automatic poke(input int addr, input int data);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = AW'(addr);
        tb_data = DW'(data);
        @(negedge clk) tb_we = 1'b0;
    endtask

    // Pulses start and returns in the DONE cycle; extra_at > 0 fires a second start mid-run.
    task automatic apply_stimulus(input int extra_at, output int lat);
        int  c0;
        bit  seen;
        seen = 1'b0;
        lat  = 0;
        @(negedge clk);
        start = 1'b1;
        c0    = cyc;
        @(negedge clk) start = 1'b0;
        for (int i = 1; i < 5000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (i == extra_at);
            @(negedge clk);
        end
        start = 1'b0;
        if (seen) lat = cyc - c0 + 1;
        else check_output("done_timeout", 64'(seen), 64'd1);
    endtask

    initial begin
        int base;
        int lat;
        int iw;
        int jw;
        int sig1;
        int d0;

        reset   = 1'b0;
        start   = 1'b0;
        tb_clr  = 1'b0;
        tb_we   = 1'b0;
        tb_addr = '0;
        tb_data = '0;
        repeat (3) @(negedge clk);
        check_output("reset_strobes", 64'({busy, done, mem_rd, mem_wr, dtu_bwd}), 64'd0);
        check_output("reset_addr_wdata", 64'({mem_addr, mem_wdata}), 64'd0);
        check_output("reset_operands", 64'({dtu_a, dtu_b, dtu_c, dtu_d, dtu_ref}), 64'd0);
        reset = 1'b1;
        clear_ram();
        check_output("idle_after_reset", 64'({busy, mem_rd}), 64'd0);

        // All-zero image
        base = log_q.size();
        apply_stimulus(0, lat);
        check_output("zero_latency", 64'(lat), 64'(ZERO_LAT));
        check_output("zero_busy_with_done", 64'(busy), 64'd1);
        check_output("zero_reads", 64'(count_acc(base, 1'b0)), 64'(2 * PIX));
        check_output("zero_writes", 64'(count_acc(base, 1'b1)), 64'd0);
        check_output("zero_first_addr", 64'({log_q[base].bwd, 8'(log_q[base].addr)}), 64'(a_of(1, 1)));
        check_output("zero_bwd_first", 64'({log_q[base+PIX].bwd, 8'(log_q[base+PIX].addr)}),
                     64'(256 + a_of(N, N)));
        check_output("zero_last_addr", 64'(log_q[log_q.size()-1].addr), 64'(a_of(1, 1)));
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_output("busy_low_after_done", 64'(busy), 64'd0);
        @(negedge clk);
        check_output("start_at_done_ignored", 64'({busy, mem_rd}), 64'd0);

        // Single object pixel in the middle
        clear_ram();
        poke(a_of(8, 8), 1);
        base = log_q.size();
        apply_stimulus(0, lat);
        check_output("one_latency", 64'(lat), 64'(ONE_LAT));
        check_output("one_writes", 64'(count_acc(base, 1'b1)), 64'd2);
        iw = find_wr(base, 0);
        jw = find_wr(base, 1);
        if (iw < base + 5 || jw < base + 5) begin
            check_output("one_write_found", 64'd0, 64'd1);
            iw = base + 5;
            jw = base + 5;
        end
        check_output("fwd_centre_read", 64'(log_q[iw-5].addr), 64'(a_of(8, 8)));
        check_output("fwd_nb_addrs", {8'(log_q[iw-4].addr), 8'(log_q[iw-3].addr),
                                      8'(log_q[iw-2].addr), 8'(log_q[iw-1].addr)},
                     {8'(a_of(7, 7)), 8'(a_of(7, 8)), 8'(a_of(7, 9)), 8'(a_of(8, 7))});
        check_output("fwd_write", 64'({log_q[iw].bwd, 8'(log_q[iw].addr), 8'(log_q[iw].wdata)}),
                     64'({1'b0, 8'(a_of(8, 8)), 8'd1}));
        check_output("object_cycle_cost", 64'(log_q[iw].cyc - log_q[iw-5].cyc), 64'd7);
        check_output("bwd_nb_addrs", {8'(log_q[jw-4].addr), 8'(log_q[jw-3].addr),
                                      8'(log_q[jw-2].addr), 8'(log_q[jw-1].addr)},
                     {8'(a_of(8, 9)), 8'(a_of(9, 7)), 8'(a_of(9, 8)), 8'(a_of(9, 9))});
        check_output("bwd_write", 64'({log_q[jw].bwd, 8'(log_q[jw].addr), 8'(log_q[jw].wdata)}),
                     64'({1'b1, 8'(a_of(8, 8)), 8'd1}));
        sig1 = signature(base);

        // Second start 100 cycles into the same run must change nothing
        clear_ram();
        poke(a_of(8, 8), 1);
        base = log_q.size();
        apply_stimulus(100, lat);
        check_output("restart_latency", 64'(lat), 64'(ONE_LAT));
        check_output("restart_sequence", 64'(signature(base)), 64'(sig1));

        // Corner pixel with distinct border neighbours
        clear_ram();
        poke(a_of(0, 0), 10);
        poke(a_of(0, 1), 20);
        poke(a_of(0, 2), 30);
        poke(a_of(1, 0), 40);
        poke(a_of(1, 1), 7);
        base = log_q.size();
        apply_stimulus(0, lat);
        iw = find_wr(base, 0);
        jw = find_wr(base, 1);
        if (iw < base + 5 || jw < base + 5) begin
            check_output("corner_write_found", 64'd0, 64'd1);
            iw = base + 5;
            jw = base + 5;
        end
        check_output("corner_nb_addrs", {8'(log_q[iw-4].addr), 8'(log_q[iw-3].addr),
                                         8'(log_q[iw-2].addr), 8'(log_q[iw-1].addr)},
                     {8'd0, 8'd1, 8'd2, 8'(a_of(1, 0))});
        check_output("corner_operands", 64'(log_q[iw].ops), 64'({8'd10, 8'd20, 8'd30, 8'd40, 8'd7}));
        check_output("corner_fwd_wdata", 64'(log_q[iw].wdata), 64'd11);
        check_output("corner_bwd_write", 64'({8'(log_q[jw].addr), 8'(log_q[jw].ops[7:0]),
                                              8'(log_q[jw].wdata)}),
                     64'({8'(a_of(1, 1)), 8'd11, 8'd1}));

        // Last interior pixel: pass switch straight into the backward pass
        clear_ram();
        poke(a_of(N, N), 3);
        base = log_q.size();
        apply_stimulus(0, lat);
        iw = find_wr(base, 0);
        if (iw < base + 5 || iw + 1 >= log_q.size()) begin
            check_output("switch_write_found", 64'd0, 64'd1);
            iw = base + 5;
        end
        check_output("switch_fwd_write", 64'({log_q[iw].bwd, 8'(log_q[iw].addr), 8'(log_q[iw].ops[7:0])}),
                     64'({1'b0, 8'(a_of(N, N)), 8'd3}));
        check_output("switch_next_rdc", 64'({log_q[iw+1].rd, log_q[iw+1].bwd, 8'(log_q[iw+1].addr)}),
                     64'({2'b11, 8'(a_of(N, N))}));
        check_output("switch_adjacent", 64'(log_q[iw+1].cyc - log_q[iw].cyc), 64'd1);
        check_output("switch_ops_cleared", 64'(log_q[iw+1].ops), 64'd0);
        check_output("no_border_writes", 64'(border_wr), 64'd0);
        check_output("no_rd_wr_overlap", 64'(both_total), 64'd0);

        // Asynchronous reset in the middle of the backward pass
        clear_ram();
        d0 = done_total;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 3000 && !dtu_bwd; i++) @(negedge clk);
        check_output("reach_backward", 64'(dtu_bwd), 64'd1);
        repeat (7) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_output("async_reset_strobes", 64'({busy, done, mem_rd, mem_wr, dtu_bwd}), 64'd0);
        check_output("async_reset_addr_ops",
                     64'({mem_addr, dtu_a, dtu_b, dtu_c, dtu_d, dtu_ref}), 64'd0);
        @(negedge clk) reset = 1'b1;
        repeat (20) @(negedge clk);
        check_output("idle_held_after_abort", 64'({busy, mem_rd, mem_wr}), 64'd0);
        check_output("no_done_after_abort", 64'(done_total - d0), 64'd0);
        base = log_q.size();
        apply_stimulus(0, lat);
        check_output("replay_first_access", 64'({log_q[base].bwd, 8'(log_q[base].addr)}), 64'(a_of(1, 1)));
        check_output("replay_latency", 64'(lat), 64'(ZERO_LAT));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
